// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: 5..8 data bits, optional parity, 1/2 stop bits, 3-sample majority,
// valid/ready output. Define UART_RX_BREAK_DET_EN to enable break detection.
module uart_rx_cfg #(
  parameter int unsigned CLK_FREQ  = 125_000_000,
  parameter int unsigned BAUD      = 9600,
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned PARITY    = 0,
  parameter int unsigned STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 rx_perr,
  output logic                 rx_ferr,
  output logic                 rx_overrun,
  output logic                 rx_break
);

  localparam int unsigned DIV   = CLK_FREQ / BAUD;
  localparam int unsigned CW    = $clog2(DIV);
  localparam int unsigned BCW   = 3;
  localparam int unsigned SAMP0 = DIV / 2 - 1;
  localparam int unsigned SAMP1 = DIV / 2;
  localparam int unsigned SAMP2 = DIV / 2 + 1;

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP, S_BRK} state_t;

  state_t               state_q, state_d;
  logic                 sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [BCW-1:0]       bit_cnt_q, bit_cnt_d;
  logic [1:0]           samp_q, samp_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 par_q, par_d;
  logic                 frm_ferr_q, frm_ferr_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 rx_perr_q, rx_perr_d;
  logic                 rx_ferr_q, rx_ferr_d;
  logic                 rx_overrun_q, rx_overrun_d;

  logic rx_s, bit_maj, decide, wrap, perr_c, frame_done;

  assign rx_s    = sync2_q;
  assign bit_maj = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_s) | (samp_q[1] & rx_s);
  assign decide  = (cnt_q == CW'(SAMP2));
  assign wrap    = (cnt_q == CW'(DIV - 1));

  always_comb begin
    if (PARITY == 1)      perr_c = ~(^shreg_q ^ par_q);
    else if (PARITY == 2) perr_c = ^shreg_q ^ par_q;
    else                  perr_c = 1'b0;
  end

`ifdef UART_RX_BREAK_DET_EN
  logic rx_break_q, rx_break_d;
`endif

  // Frame FSM, bit timing and delivery into the holding register
  always_comb begin
    sync1_d      = rx;
    sync2_d      = sync1_q;
    prev_d       = sync2_q;
    state_d      = state_q;
    cnt_d        = cnt_q;
    bit_cnt_d    = bit_cnt_q;
    samp_d       = samp_q;
    shreg_d      = shreg_q;
    par_d        = par_q;
    frm_ferr_d   = frm_ferr_q;
    rx_data_d    = rx_data_q;
    rx_perr_d    = rx_perr_q;
    rx_ferr_d    = rx_ferr_q;
    rx_valid_d   = rx_valid_q & ~rx_ready;
    rx_overrun_d = 1'b0;
    frame_done   = 1'b0;
`ifdef UART_RX_BREAK_DET_EN
    rx_break_d   = 1'b0;
`endif

    if (cnt_q == CW'(SAMP0)) samp_d[0] = rx_s;
    if (cnt_q == CW'(SAMP1)) samp_d[1] = rx_s;
    if (state_q != S_IDLE && state_q != S_BRK) cnt_d = wrap ? '0 : cnt_q + CW'(1);

    case (state_q)
      S_IDLE: begin
        cnt_d      = '0;
        bit_cnt_d  = '0;
        par_d      = 1'b0;
        frm_ferr_d = 1'b0;
        if (prev_q && !rx_s) state_d = S_START;
      end
      S_START: begin
        if (decide && bit_maj) begin
          state_d = S_IDLE;
        end else if (wrap) begin
          state_d   = S_DATA;
          bit_cnt_d = '0;
        end
      end
      S_DATA: begin
        if (decide) shreg_d = {bit_maj, shreg_q[DATA_BITS-1:1]};
        if (wrap) begin
          if (bit_cnt_q == BCW'(DATA_BITS - 1)) begin
            bit_cnt_d = '0;
            state_d   = (PARITY != 0) ? S_PAR : S_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + BCW'(1);
          end
        end
      end
      S_PAR: begin
        if (decide) par_d = bit_maj;
        if (wrap) state_d = S_STOP;
      end
      S_STOP: begin
        if (decide) begin
          frm_ferr_d = frm_ferr_q | ~bit_maj;
          if (bit_cnt_q == BCW'(STOP_BITS - 1)) begin
            state_d    = S_IDLE;
            frame_done = 1'b1;
          end
        end
        if (wrap) bit_cnt_d = bit_cnt_q + BCW'(1);
      end
      S_BRK: begin
        // Leave only after the line has been high for a whole bit time
        if (!rx_s) begin
          cnt_d = '0;
        end else if (wrap) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (frame_done) begin
`ifdef UART_RX_BREAK_DET_EN
      if (shreg_q == '0 && !par_q && !bit_maj) begin
        rx_break_d = 1'b1;
        state_d    = S_BRK;
        cnt_d      = '0;
      end else
`endif
      if (!rx_valid_q || rx_ready) begin
        rx_data_d  = shreg_q;
        rx_perr_d  = perr_c;
        rx_ferr_d  = frm_ferr_q | ~bit_maj;
        rx_valid_d = 1'b1;
      end else begin
        rx_overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q      <= 1'b1;
      sync2_q      <= 1'b1;
      prev_q       <= 1'b1;
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      bit_cnt_q    <= '0;
      samp_q       <= '0;
      shreg_q      <= '0;
      par_q        <= 1'b0;
      frm_ferr_q   <= 1'b0;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      rx_perr_q    <= 1'b0;
      rx_ferr_q    <= 1'b0;
      rx_overrun_q <= 1'b0;
    end else begin
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      prev_q       <= prev_d;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      samp_q       <= samp_d;
      shreg_q      <= shreg_d;
      par_q        <= par_d;
      frm_ferr_q   <= frm_ferr_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      rx_perr_q    <= rx_perr_d;
      rx_ferr_q    <= rx_ferr_d;
      rx_overrun_q <= rx_overrun_d;
    end
  end

`ifdef UART_RX_BREAK_DET_EN
  always_ff @(posedge clk) begin
    if (rst) rx_break_q <= 1'b0;
    else     rx_break_q <= rx_break_d;
  end
  assign rx_break = rx_break_q;
`else
  assign rx_break = 1'b0;
`endif

  assign rx_data    = rx_data_q;
  assign rx_valid   = rx_valid_q;
  assign rx_perr    = rx_perr_q;
  assign rx_ferr    = rx_ferr_q;
  assign rx_overrun = rx_overrun_q;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Bench for uart_rx_cfg: three configurations (8N1, 7E2, 6O1) at DIV=16, checked against
// a frame-level reference model of delivered words, overrun and break pulses.
module tb_uart_rx_cfg;

  localparam int unsigned DIV = 16;

  typedef struct packed {
    logic [1:0] idx;
    logic [7:0] data;
    logic       perr;
    logic       ferr;
  } word_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] rx_v, rdy_v, vld_v, perr_v, ferr_v, ovr_v, brk_v;
  logic [7:0] dat0;
  logic [6:0] dat1;
  logic [5:0] dat2;

  int cfg_db[3]  = '{8, 7, 6};
  int cfg_par[3] = '{0, 2, 1};
  int cfg_sb[3]  = '{1, 2, 1};

  int    errors = 0;
  int    checks = 0;
  int    cyc = 0;
  int    last_stop_cyc = 0;
  int    ovr_cnt[3] = '{0, 0, 0};
  int    brk_cnt[3] = '{0, 0, 0};
  int    rise_cyc[3] = '{0, 0, 0};
  logic [2:0] vld_prev = 3'b000;
  word_t obs_q[$];

  always #5 clk = ~clk;

  uart_rx_cfg #(.CLK_FREQ(16), .BAUD(1), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u0 (
    .clk(clk), .rst(rst), .rx(rx_v[0]), .rx_data(dat0), .rx_valid(vld_v[0]), .rx_ready(rdy_v[0]),
    .rx_perr(perr_v[0]), .rx_ferr(ferr_v[0]), .rx_overrun(ovr_v[0]), .rx_break(brk_v[0]));
  uart_rx_cfg #(.CLK_FREQ(16), .BAUD(1), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2)) u1 (
    .clk(clk), .rst(rst), .rx(rx_v[1]), .rx_data(dat1), .rx_valid(vld_v[1]), .rx_ready(rdy_v[1]),
    .rx_perr(perr_v[1]), .rx_ferr(ferr_v[1]), .rx_overrun(ovr_v[1]), .rx_break(brk_v[1]));
  uart_rx_cfg #(.CLK_FREQ(16), .BAUD(1), .DATA_BITS(6), .PARITY(1), .STOP_BITS(1)) u2 (
    .clk(clk), .rst(rst), .rx(rx_v[2]), .rx_data(dat2), .rx_valid(vld_v[2]), .rx_ready(rdy_v[2]),
    .rx_perr(perr_v[2]), .rx_ferr(ferr_v[2]), .rx_overrun(ovr_v[2]), .rx_break(brk_v[2]));

  function automatic logic [7:0] dat_of(input int i);
    case (i)
      0:       return dat0;
      1:       return {1'b0, dat1};
      default: return {2'b00, dat2};
    endcase
  endfunction

  function automatic logic [7:0] mask_of(input int i);
    return 8'((1 << cfg_db[i]) - 1);
  endfunction

  // Reference model: what the consumer should see for one transmitted frame
  function automatic word_t model(input int i, input logic [7:0] d, input logic flip, input logic [1:0] sv);
    word_t m;
    m.idx  = 2'(i);
    m.data = d & mask_of(i);
    m.perr = (cfg_par[i] != 0) && flip;
    m.ferr = (cfg_sb[i] == 2) ? !(sv[0] && sv[1]) : !sv[0];
    return m;
  endfunction

  // Handshake monitor on the falling edge
  always @(negedge clk) begin
    cyc++;
    for (int i = 0; i < 3; i++) begin
      if (vld_v[i] && rdy_v[i]) obs_q.push_back(word_t'{2'(i), dat_of(i), perr_v[i], ferr_v[i]});
      if (ovr_v[i]) ovr_cnt[i]++;
      if (brk_v[i]) brk_cnt[i]++;
      if (vld_v[i] && !vld_prev[i]) rise_cyc[i] = cyc;
    end
    vld_prev = vld_v;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic drive_bit(input int i, input logic b);
    rx_v[i] = b;
    tick(DIV);
  endtask

  task automatic send_frame(input int i, input logic [7:0] d, input logic flip, input logic [1:0] sv, input int gap);
    int   ones;
    logic pbit;
    drive_bit(i, 1'b0);
    for (int k = 0; k < cfg_db[i]; k++) drive_bit(i, d[k]);
    if (cfg_par[i] != 0) begin
      ones = $countones(d & mask_of(i));
      pbit = (cfg_par[i] == 1) ? (ones % 2 == 0) : (ones % 2 == 1);
      drive_bit(i, pbit ^ flip);
    end
    for (int s = 0; s < cfg_sb[i]; s++) begin
      last_stop_cyc = cyc;
      drive_bit(i, sv[s]);
    end
    rx_v[i] = 1'b1;
    tick(gap);
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    rx_v  = 3'b111;
    rdy_v = 3'b111;
    tick(3);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({vld_v[i], perr_v[i], ferr_v[i], ovr_v[i], brk_v[i]} !== 5'b0)
        $display("FAIL reset_flags[%0d]: got %b expected 00000", i, {vld_v[i], perr_v[i], ferr_v[i], ovr_v[i], brk_v[i]});
      if ({vld_v[i], perr_v[i], ferr_v[i], ovr_v[i], brk_v[i]} !== 5'b0) errors++;
      checks++;
      if (dat_of(i) !== 8'h00) begin
        errors++;
        $display("FAIL reset_data[%0d]: got %h expected 00", i, dat_of(i));
      end
    end
    rst = 1'b0;
    tick(2);
  endtask

  task automatic test_8n1();
    int    base = obs_q.size();
    int    lat;
    word_t exp = '{2'd0, 8'hA5, 1'b0, 1'b0};
    send_frame(0, 8'hA5, 1'b0, 2'b11, 4);
    checks++;
    if (obs_q.size() - base !== 1) begin
      errors++;
      $display("FAIL 8n1_count: got %0d words expected 1", obs_q.size() - base);
    end else begin
      checks++;
      if (obs_q[base] !== exp) begin
        errors++;
        $display("FAIL 8n1_word: got %h expected %h", obs_q[base], exp);
      end
    end
    lat = rise_cyc[0] - last_stop_cyc;
    checks++;
    if (lat < 13 || lat > 15) begin
      errors++;
      $display("FAIL 8n1_latency: got %0d expected 14", lat);
    end
    checks++;
    if (vld_v[0] !== 1'b0) begin
      errors++;
      $display("FAIL 8n1_valid_drop: got %b expected 0", vld_v[0]);
    end
  endtask

  task automatic test_parity();
    int    base = obs_q.size();
    word_t exp = '{2'd1, 8'h41, 1'b1, 1'b0};
    send_frame(1, 8'h41, 1'b1, 2'b11, 4);
    checks++;
    if (obs_q.size() - base !== 1) begin
      errors++;
      $display("FAIL parity_count: got %0d words expected 1", obs_q.size() - base);
    end else if (obs_q[base] !== exp) begin
      errors++;
      $display("FAIL parity_word: got %h expected %h", obs_q[base], exp);
    end
  endtask

  task automatic test_stop2_ferr();
    int         base = obs_q.size();
    logic [7:0] d = 8'($urandom_range(1, 127));
    word_t      exp = '{2'd1, d, 1'b0, 1'b1};
    send_frame(1, d, 1'b0, 2'b01, 2 * DIV);
    checks++;
    if (obs_q.size() - base !== 1) begin
      errors++;
      $display("FAIL stop2_count: got %0d words expected 1", obs_q.size() - base);
    end else if (obs_q[base] !== exp) begin
      errors++;
      $display("FAIL stop2_word: got %h expected %h", obs_q[base], exp);
    end
  endtask

  task automatic test_glitch();
    int    base = obs_q.size();
    word_t exp = '{2'd0, 8'h3C, 1'b0, 1'b0};
    rx_v[0] = 1'b0;
    tick(5);
    rx_v[0] = 1'b1;
    tick(2 * DIV);
    checks++;
    if (obs_q.size() !== base || vld_v[0] !== 1'b0) begin
      errors++;
      $display("FAIL glitch_reject: got %0d words valid=%b expected 0 words valid=0", obs_q.size() - base, vld_v[0]);
    end
    send_frame(0, 8'h3C, 1'b0, 2'b11, 4);
    checks++;
    if (obs_q.size() - base !== 1 || obs_q[obs_q.size() - 1] !== exp) begin
      errors++;
      $display("FAIL glitch_recover: got %0d words last=%h expected 1 word %h", obs_q.size() - base, obs_q[obs_q.size() - 1], exp);
    end
  endtask

  task automatic test_overrun();
    int base = obs_q.size();
    int o = ovr_cnt[0];
    rdy_v[0] = 1'b0;
    send_frame(0, 8'h11, 1'b0, 2'b11, 2);
    send_frame(0, 8'h22, 1'b0, 2'b11, 4);
    checks++;
    if (vld_v[0] !== 1'b1 || dat_of(0) !== 8'h11) begin
      errors++;
      $display("FAIL overrun_hold: got valid=%b data=%h expected valid=1 data=11", vld_v[0], dat_of(0));
    end
    checks++;
    if (ovr_cnt[0] - o !== 1) begin
      errors++;
      $display("FAIL overrun_pulse: got %0d pulses expected 1", ovr_cnt[0] - o);
    end
    rdy_v[0] = 1'b1;
    tick(1);
    checks++;
    if (vld_v[0] !== 1'b0 || obs_q.size() - base !== 1) begin
      errors++;
      $display("FAIL overrun_accept: got valid=%b words=%0d expected valid=0 words=1", vld_v[0], obs_q.size() - base);
    end else begin
      checks++;
      if (obs_q[base].data !== 8'h11) begin
        errors++;
        $display("FAIL overrun_data: got %h expected 11", obs_q[base].data);
      end
    end
  endtask

  task automatic test_break();
    int    base = obs_q.size();
    int    b = brk_cnt[0];
    int    o = ovr_cnt[0];
    word_t exp = '{2'd0, 8'h00, 1'b0, 1'b1};
    rx_v[0] = 1'b0;
    tick(12 * DIV);
    rx_v[0] = 1'b1;
    tick(2 * DIV);
`ifdef UART_RX_BREAK_DET_EN
    checks++;
    if (brk_cnt[0] - b !== 1 || obs_q.size() !== base || ovr_cnt[0] - o !== 0) begin
      errors++;
      $display("FAIL break_detect: got pulses=%0d words=%0d overruns=%0d expected 1/0/0", brk_cnt[0] - b, obs_q.size() - base, ovr_cnt[0] - o);
    end
`else
    checks++;
    if (brk_cnt[0] - b !== 0 || obs_q.size() - base !== 1 || ovr_cnt[0] - o !== 0) begin
      errors++;
      $display("FAIL break_as_data: got pulses=%0d words=%0d overruns=%0d expected 0/1/0", brk_cnt[0] - b, obs_q.size() - base, ovr_cnt[0] - o);
    end else begin
      checks++;
      if (obs_q[base] !== exp) begin
        errors++;
        $display("FAIL break_word: got %h expected %h", obs_q[base], exp);
      end
    end
`endif
    base = obs_q.size();
    send_frame(0, 8'h5A, 1'b0, 2'b11, 4);
    checks++;
    if (obs_q.size() - base !== 1 || obs_q[obs_q.size() - 1].data !== 8'h5A) begin
      errors++;
      $display("FAIL break_recover: got %0d words last=%h expected 1 word 5a", obs_q.size() - base, obs_q[obs_q.size() - 1].data);
    end
  endtask

  task automatic test_reset_midframe();
    int base = obs_q.size();
    int o = ovr_cnt[0];
    rx_v[0] = 1'b0;
    tick(5 * DIV);
    rst     = 1'b1;
    rx_v[0] = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(2 * DIV);
    checks++;
    if (obs_q.size() !== base || vld_v[0] !== 1'b0 || ovr_cnt[0] !== o) begin
      errors++;
      $display("FAIL rst_midframe: got words=%0d valid=%b overruns=%0d expected 0/0/0", obs_q.size() - base, vld_v[0], ovr_cnt[0] - o);
    end
    send_frame(0, 8'hC3, 1'b0, 2'b11, 4);
    checks++;
    if (obs_q.size() - base !== 1 || obs_q[obs_q.size() - 1].data !== 8'hC3) begin
      errors++;
      $display("FAIL rst_recover: got %0d words last=%h expected 1 word c3", obs_q.size() - base, obs_q[obs_q.size() - 1].data);
    end
  endtask

  task automatic test_back_to_back();
    for (int u = 0; u < 3; u++) begin
      word_t      exp[$];
      int         base = obs_q.size();
      logic [7:0] d;
      logic       flip;
      logic [1:0] sv;
      int         gap;
      for (int k = 0; k < 8; k++) begin
        d    = 8'($urandom) & mask_of(u);
        flip = (cfg_par[u] != 0) && ($urandom_range(0, 3) == 0);
        sv   = 2'b11;
        gap  = $urandom_range(0, 3);
        if ($urandom_range(0, 4) == 0) begin
          sv  = (cfg_sb[u] == 2) ? 2'($urandom_range(0, 2)) : 2'b00;
          gap = 2 * DIV;
          if (d == 8'h00) d = 8'h01;
        end
        exp.push_back(model(u, d, flip, sv));
        send_frame(u, d, flip, sv, gap);
      end
      tick(8);
      checks++;
      if (obs_q.size() - base !== exp.size()) begin
        errors++;
        $display("FAIL b2b_count[%0d]: got %0d words expected %0d", u, obs_q.size() - base, exp.size());
      end else begin
        for (int k = 0; k < exp.size(); k++) begin
          checks++;
          if (obs_q[base + k] !== exp[k]) begin
            errors++;
            $display("FAIL b2b_word[%0d][%0d]: got %h expected %h", u, k, obs_q[base + k], exp[k]);
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_8n1();
    test_parity();
    test_stop2_ferr();
    test_glitch();
    test_overrun();
    test_break();
    test_reset_midframe();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
